pulse_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for one shared pulse line `out`.
- Each requester asks, over a 4-phase req/ack handshake, for `out` to go high for `len` consecutive clocks.
- The block grants one requester, drives the pulse, holds a low guard gap, then acknowledges.
- Sits between control FSMs and a shared strobe/enable line that must never carry overlapping pulses.

---
 rtl/pulse_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_pulse_rr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_rr_arbiter.sv
// Purpose : two-requester arbiter/sequencer for one shared pulse line `out`.
//           A grant drives `out` high for len clocks, holds a low guard gap,
//           then acks over a 4-phase req/ack handshake.
// Latency : req sampled at edge k -> out=1 for cycles k+1..k+len, ack from edge k+len+GAP.
// Backpressure: a requester holds req until it sees ack. The block is busy
//           from the grant until the granted req falls in ACK.
// Build option: define PULSE_RR_ARBITER_FIXED_PRIO_EN to replace round-robin
//           with fixed priority (A always wins ties). The default build is round-robin.
// Ports   : clock/reset (sync, active-high); req_x/len_x/ack_x per requester;
//           out (registered pulse); busy (state != IDLE); gnt_b (current/last grant, 1=B).
module pulse_rr_arbiter #(
    parameter int W   = 4,
    parameter int GAP = 1   // legal range 1..15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_a,
    input  logic [W-1:0] len_a,
    output logic         ack_a,
    input  logic         req_b,
    input  logic [W-1:0] len_b,
    output logic         ack_b,
    output logic         out,
    output logic         busy,
    output logic         gnt_b
);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_ACK} state_t;

    localparam logic [3:0] GAP_L = 4'(GAP);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [3:0]     gcnt_q, gcnt_d;
    logic           out_q, out_d;
    logic           ack_a_q, ack_a_d;
    logic           ack_b_q, ack_b_d;
    logic           gnt_b_q, gnt_b_d;
    logic           pick_b;
    logic           gnt_req;
    logic [W-1:0]   len_sel;

`ifdef PULSE_RR_ARBITER_FIXED_PRIO_EN
    // B only wins when A is not asking.
    assign pick_b = req_b & ~req_a;
`else
    // last_q = 1 means B was served last, so A wins the first tie after reset.
    logic last_q, last_d;
    assign pick_b = req_b & (~req_a | ~last_q);
`endif

    // Request line of whoever currently holds the grant.
    assign gnt_req = gnt_b_q ? req_b : req_a;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        out_d   = out_q;
        ack_a_d = ack_a_q;
        ack_b_d = ack_b_q;
        gnt_b_d = gnt_b_q;
        len_sel = pick_b ? len_b : len_a;
`ifndef PULSE_RR_ARBITER_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    gnt_b_d = pick_b;
                    cnt_d   = len_sel;
                    if (len_sel != '0) begin
                        out_d   = 1'b1;
                        state_d = S_PULSE;
                    end else begin
                        // Zero-length request: skip the pulse but still run the gap and ack.
                        gcnt_d  = GAP_L;
                        state_d = S_GAP;
                    end
                end
            end
            S_PULSE: begin
                cnt_d = cnt_q - W'(1);
                if (cnt_q == W'(1)) begin
                    out_d   = 1'b0;
                    gcnt_d  = GAP_L;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                gcnt_d = gcnt_q - 4'd1;
                if (gcnt_q == 4'd1) begin
                    if (gnt_b_q) ack_b_d = 1'b1;
                    else         ack_a_d = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // A req that dropped early still yields a one-cycle ack here.
                if (!gnt_req) begin
                    ack_a_d = 1'b0;
                    ack_b_d = 1'b0;
`ifndef PULSE_RR_ARBITER_FIXED_PRIO_EN
                    last_d  = gnt_b_q;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            out_q   <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            gnt_b_q <= 1'b0;
`ifndef PULSE_RR_ARBITER_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            out_q   <= out_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            gnt_b_q <= gnt_b_d;
`ifndef PULSE_RR_ARBITER_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign out   = out_q;
    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign gnt_b = gnt_b_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_rr_arbiter.sv
module tb_pulse_rr_arbiter;

    localparam int W   = 4;
    localparam int GAP = 1;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_a, req_b;
    logic [W-1:0] len_a, len_b;
    logic         ack_a, ack_b, out, busy, gnt_b;

    int tests = 0;
    int fails = 0;

    pulse_rr_arbiter #(.W(W), .GAP(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .req_a (req_a),
        .len_a (len_a),
        .ack_a (ack_a),
        .req_b (req_b),
        .len_b (len_b),
        .ack_b (ack_b),
        .out   (out),
        .busy  (busy),
        .gnt_b (gnt_b)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per expected ack, pushed when the request is driven.
    typedef struct {
        bit is_b;
        int hi;
    } exp_t;
    exp_t sb_q[$];

    // Monitor: measures each served transaction at the rising ack.
    int hi_cnt = 0;
    int lo_cnt = 0;
    bit prev_ack = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            hi_cnt   = 0;
            lo_cnt   = 0;
            prev_ack = 1'b0;
        end else begin
            chk("ack_exclusive", int'(ack_a & ack_b), 0);
            chk("out_only_when_busy", int'(out & ~busy), 0);
            if ((ack_a || ack_b) && !prev_ack) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_ack_b", int'(ack_b), int'(e.is_b));
                    chk("sb_gnt_b", int'(gnt_b), int'(e.is_b));
                    chk("sb_pulse_len", hi_cnt, e.hi);
                    if (e.hi != 0) chk("sb_gap_len", lo_cnt, GAP);
                end
                hi_cnt = 0;
                lo_cnt = 0;
            end
            if (out) begin
                hi_cnt++;
                lo_cnt = 0;
            end else begin
                lo_cnt++;
            end
            prev_ack = ack_a | ack_b;
        end
    end

    function automatic bit ack_of(input bit b);
        return b ? ack_b : ack_a;
    endfunction

    task automatic set_req(input bit b, input bit v);
        if (b) req_b = v;
        else   req_a = v;
    endtask

    task automatic set_len(input bit b, input logic [W-1:0] l);
        if (b) len_b = l;
        else   len_a = l;
    endtask

    task automatic push(input bit b, input int hi);
        exp_t e;
        e.is_b = b;
        e.hi   = hi;
        sb_q.push_back(e);
    endtask

    // Waits for the ack of requester b, then closes the handshake.
    task automatic close_txn(input bit b, input bit dropped, input bit exp_gnt);
        int n = 0;
        while (ack_of(b) !== 1'b1 && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ack_rise_in_time", int'(n < 300), 1);
        if (n >= 300) begin
            set_req(b, 1'b0);
            return;
        end
        chk("gnt_b_at_ack", int'(gnt_b), int'(exp_gnt));
        if (dropped) begin
            @(posedge clock); #1;
            chk("ack_single_cycle", int'(ack_of(b)), 0);
            chk("busy_after_drop", int'(busy), 0);
        end else begin
            repeat (2) begin
                @(posedge clock); #1;
            end
            chk("ack_held", int'(ack_of(b)), 1);
            set_req(b, 1'b0);
            n = 0;
            do begin
                @(posedge clock); #1;
                n++;
            end while (ack_of(b) === 1'b1 && n < 10);
            chk("ack_fall", int'(ack_of(b)), 0);
            chk("busy_after_close", int'(busy), 0);
        end
    endtask

    typedef struct {
        bit           is_b;
        logic [W-1:0] len;
        bit           chg;       // change len to 9 mid-pulse
        bit           drop;      // drop req after one pulse cycle
        int           exp_hi;
        bit           exp_gnt_b;
    } vec_t;

    task automatic serve(input vec_t v);
        @(posedge clock); #1;
        set_len(v.is_b, v.len);
        set_req(v.is_b, 1'b1);
        push(v.is_b, v.exp_hi);
        if (v.chg) begin
            repeat (2) @(posedge clock);
            #1;
            set_len(v.is_b, 4'd9);
        end
        if (v.drop) begin
            repeat (2) @(posedge clock);
            #1;
            set_req(v.is_b, 1'b0);
        end
        close_txn(v.is_b, v.drop, v.exp_gnt_b);
    endtask

    task automatic tie(input logic [W-1:0] la, input logic [W-1:0] lb, input bit first_b);
        @(posedge clock); #1;
        len_a = la;
        len_b = lb;
        req_a = 1'b1;
        req_b = 1'b1;
        push(first_b, first_b ? int'(lb) : int'(la));
        push(!first_b, first_b ? int'(la) : int'(lb));
        close_txn(first_b, 1'b0, first_b);
        close_txn(!first_b, 1'b0, !first_b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 4'd1,  1'b0, 1'b0, 1,  1'b0};
        vecs[1] = '{1'b1, 4'd7,  1'b0, 1'b0, 7,  1'b1};
        vecs[2] = '{1'b0, 4'd15, 1'b0, 1'b0, 15, 1'b0};
        vecs[3] = '{1'b1, 4'd0,  1'b0, 1'b0, 0,  1'b1};
        vecs[4] = '{1'b0, 4'd3,  1'b1, 1'b0, 3,  1'b0};
        vecs[5] = '{1'b0, 4'd4,  1'b0, 1'b1, 4,  1'b0};
        vecs[6] = '{1'b1, 4'd2,  1'b0, 1'b1, 2,  1'b1};

        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        len_a = '0;
        len_b = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_ack_a", int'(ack_a), 0);
        chk("rst_ack_b", int'(ack_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gnt_b", int'(gnt_b), 0);
        reset = 1'b0;

        // Exact latency of a 3-clock pulse for A.
        @(posedge clock); #1;
        len_a = 4'd3;
        req_a = 1'b1;
        push(1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            chk($sformatf("t1_out_%0d", i), int'(out), int'(i < 3));
            chk($sformatf("t1_ack_%0d", i), int'(ack_a), int'(i >= 3 + GAP));
            chk($sformatf("t1_busy_%0d", i), int'(busy), 1);
        end
        req_a = 1'b0;
        @(posedge clock); #1;
        chk("t1_ack_fall", int'(ack_a), 0);
        chk("t1_busy_fall", int'(busy), 0);

        // Zero-length request from B.
        @(posedge clock); #1;
        len_b = 4'd0;
        req_b = 1'b1;
        push(1'b1, 0);
        for (int i = 0; i < GAP + 2; i++) begin
            @(posedge clock); #1;
            chk($sformatf("t3_out_%0d", i), int'(out), 0);
            chk($sformatf("t3_ack_%0d", i), int'(ack_b), int'(i >= GAP));
            chk($sformatf("t3_busy_%0d", i), int'(busy), 1);
        end
        chk("t3_gnt_b", int'(gnt_b), 1);
        req_b = 1'b0;
        @(posedge clock); #1;
        chk("t3_ack_fall", int'(ack_b), 0);
        chk("t3_busy_fall", int'(busy), 0);

        for (int i = 0; i < 7; i++) serve(vecs[i]);

        // Reset in the middle of a 15-clock pulse, req_a kept high.
        @(posedge clock); #1;
        len_a = 4'd15;
        req_a = 1'b1;
        repeat (7) @(posedge clock);
        #1;
        chk("t4_out_before_rst", int'(out), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t4_out_rst", int'(out), 0);
        chk("t4_ack_rst", int'(ack_a), 0);
        chk("t4_busy_rst", int'(busy), 0);
        reset = 1'b0;
        push(1'b0, 15);
        @(posedge clock); #1;
        chk("t4_fresh_out", int'(out), 1);
        close_txn(1'b0, 1'b0, 1'b0);

        // Ties: after reset A wins, then B; reasserted both -> A again.
        do_reset();
        tie(4'd2, 4'd1, 1'b0);
        tie(4'd2, 4'd1, 1'b0);
        // After A alone, a tie goes to B under round-robin, to A under fixed priority.
        serve('{1'b0, 4'd2, 1'b0, 1'b0, 2, 1'b0});
`ifdef PULSE_RR_ARBITER_FIXED_PRIO_EN
        tie(4'd4, 4'd5, 1'b0);
`else
        tie(4'd4, 4'd5, 1'b1);
`endif

        repeat (5) @(posedge clock);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
